// File: rtl/wrap_led_sequencer_if.sv
// rtl/wrap_led_sequencer_if.sv - switch/period inputs and LED/status outputs of the LED sequencer
interface wrap_led_sequencer_if;
  logic       sw0;
  logic       sw1;
  logic       sw2;
  logic [7:0] cnt;
  logic       led0;
  logic       led1;
  logic       led2;
  logic       led3;
  logic       step;
  logic       busy;

  modport master (
    output sw0, sw1, sw2, cnt,
    input  led0, led1, led2, led3, step, busy
  );

  modport slave (
    input  sw0, sw1, sw2, cnt,
    output led0, led1, led2, led3, step, busy
  );
endinterface

// File: rtl/wrap_led_sequencer.sv
// rtl/wrap_led_sequencer.sv - one-hot rotating four-LED sequencer with run/hold FSM and step prescaler
// Optional feature macro: SW_SYNC_EN (sw0..sw2 pass through SW_SYNC_STAGES flops before the FSM)
module wrap_led_sequencer #(
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  wrap_led_sequencer_if.slave        bus
);

`ifdef SW_SYNC_EN
  localparam int SYNC_DEPTH = SW_SYNC_STAGES;
`else
  localparam int SYNC_DEPTH = 0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  logic [2:0] sw_s;
  logic       run;
  logic       dir;
  logic       hold;
  logic [7:0] cnt_eff;

  state_t     state;
  logic [3:0] pattern;
  logic [7:0] timer;
  logic [7:0] period;
  logic       step_q;
  logic       busy_q;

  generate
    if (SYNC_DEPTH > 0) begin : g_sync
      logic [2:0] pipe [SYNC_DEPTH];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < SYNC_DEPTH; i++) pipe[i] <= 3'b000;
        end else begin
          pipe[0] <= {bus.sw2, bus.sw1, bus.sw0};
          for (int i = 1; i < SYNC_DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign sw_s = pipe[SYNC_DEPTH-1];
    end else begin : g_direct
      assign sw_s = {bus.sw2, bus.sw1, bus.sw0};
    end
  endgenerate

  assign run     = sw_s[0];
  assign dir     = sw_s[1];
  assign hold    = sw_s[2];
  assign cnt_eff = (bus.cnt == 8'd0) ? 8'd1 : bus.cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pattern <= 4'b0000;
      timer   <= 8'd0;
      period  <= 8'd1;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      // Dropping run wins over hold and over a step due this cycle.
      if (state != IDLE && !run) begin
        state   <= IDLE;
        pattern <= 4'b0000;
        timer   <= 8'd0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pattern <= 4'b0000;
            timer   <= 8'd0;
            if (run) begin
              state  <= LOAD;
              busy_q <= 1'b1;
            end
          end
          LOAD: begin
            period  <= cnt_eff;
            timer   <= 8'd0;
            pattern <= 4'b0001;
            state   <= RUN;
          end
          RUN: begin
            if (hold) begin
              state <= HOLD;
            end else if (timer == period - 8'd1) begin
              timer   <= 8'd0;
              step_q  <= 1'b1;
              period  <= cnt_eff;
              pattern <= dir ? {pattern[0], pattern[3:1]} : {pattern[2:0], pattern[3]};
            end else begin
              timer <= timer + 8'd1;
            end
          end
          HOLD: begin
            if (!hold) state <= RUN;
          end
          default: begin
            state   <= IDLE;
            pattern <= 4'b0000;
            timer   <= 8'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.led0 = pattern[0];
  assign bus.led1 = pattern[1];
  assign bus.led2 = pattern[2];
  assign bus.led3 = pattern[3];
  assign bus.step = step_q;
  assign bus.busy = busy_q;

endmodule
